bus_master_ctrl: RTL
====================

// Module: bus_master_ctrl
// PURPOSE
//  Synthesizable initiator for the if_bus req/gnt/start/rdy protocol; the requester-side counterpart to the memory responder.
//  Converts a valid/ready command stream (read/write, addr, wdata) into one bus transaction at a time.
//  Returns the read data or error on a valid/ready response channel. Sits between core logic and the shared bus.
// PARAMETERS
//  AW              8   bus_addr / cmd_addr width
//  DW              8   data width
//  TIMEOUT_CYCLES  16  max WAIT cycles before abort (used only with BUS_MASTER_TIMEOUT_EN); must be >= 2
// PORTS
//  clk          in   1   clock; all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when valid&ready
//  cmd_mode     in   2   0=read, 1=write, 2/3 reserved
//  cmd_addr     in   AW  target address
//  cmd_wdata    in   DW  write data
//  rsp_valid    out  1   response held until rsp_ready
//  rsp_ready    in   1   response consumed
//  rsp_rdata    out  DW  read data (0 for write/error)
//  rsp_err      out  1   reserved mode or timeout
//  bus_req      out  1   bus request
//  bus_gnt      in   1   bus grant
//  bus_start    out  1   one-cycle transaction start strobe
//  bus_rdy      in   1   responder done
//  bus_mode     out  2   transaction mode
//  bus_addr     out  AW  transaction address
//  bus_data_o   out  DW  write data; parent drives bus.data = bus_data_oe ? bus_data_o : 'z
//  bus_data_oe  out  1   data output enable
//  bus_data_i   in   DW  sampled bus.data
// BEHAVIOUR
//  Reset: all outputs 0, except cmd_ready=1 (state IDLE); outputs return to these values immediately on rst_n low, including mid-transaction.
//  FSM IDLE->REQ->START->WAIT->RESP->IDLE. cmd_mode/addr/wdata are registered on acceptance.
//  IDLE: cmd_ready=1 (only in IDLE). Accept mode 0/1 -> REQ. Accept mode 2/3 -> RESP with err=1; no bus activity.
//  REQ: bus_req=1. Stays until bus_gnt sampled 1 -> START.
//  START: exactly one cycle. bus_start=1, bus_req=1, bus_mode/bus_addr valid. For a write, bus_data_oe=1. -> WAIT.
//  WAIT: bus_req, mode and addr held; for a write, bus_data_oe held.
//    bus_rdy sampled 1 -> RESP; a read captures bus_data_i into rsp_rdata.
//    Deassertion of bus_gnt in WAIT is ignored.
//  RESP: rsp_valid=1; bus_req=0, bus_data_oe=0, bus_mode/bus_addr=0.
//    rsp_valid&rsp_ready -> IDLE; a new command is accepted no earlier than the next cycle.
//  Min latency from accept to rsp_valid, with gnt and rdy already high: 4 cycles (REQ, START, WAIT, RESP).
//  Back-to-back: bus_req drops for at least 2 cycles between transactions (RESP, IDLE).
//  rsp_rdata and rsp_err are stable while rsp_valid=1; both are cleared on leaving RESP.
// CONFIGURATION
//  `BUS_MASTER_TIMEOUT_EN defined:
//    The WAIT counter starts at 0 on entering WAIT and increments each WAIT cycle without bus_rdy.
//    When it equals TIMEOUT_CYCLES-1 and bus_rdy=0 -> RESP with rsp_err=1, rsp_rdata=0.
//    If bus_rdy=1 on that same cycle, rdy wins (normal completion).
//  Not defined: no counter is instantiated; WAIT waits for bus_rdy indefinitely; rsp_err is set only for reserved modes.
// STRUCTURE
//  bus_master_pkg: mode_e {MODE_RD=2'd0, MODE_WR=2'd1, MODE_RSV2, MODE_RSV3}; state_e {IDLE,REQ,START,WAIT,RESP}.
//  Sub-module bus_master_timeout (counter; inputs clr/en; output expired), instantiated only under `BUS_MASTER_TIMEOUT_EN.
//  Counter width is a localparam: $clog2(TIMEOUT_CYCLES).
// TESTING
//  1 Reset: drive rst_n=0 -> cmd_ready=1 and every other output 0. Assert rst_n=0 while in WAIT -> same values in the same cycle.
//  2 Write: mode=1, addr=8'h3C, wdata=8'hA5; gnt high; rdy 2 cycles after start
//    -> bus_start is a single pulse with addr 3C; bus_data_oe=1 from START through WAIT; rsp_valid with err=0, rdata=0.
//  3 Read: mode=0, addr=8'h10; gnt delayed 5 cycles; rdy with bus_data_i=8'h5A
//    -> bus_req high for 5 cycles before START; bus_data_oe never 1; rsp_rdata=5A.
//  4 Reserved: mode=2 -> bus_req never asserts; rsp_valid with err=1 one cycle after accept.
//    Hold rsp_ready=0 for 3 cycles -> rsp_valid held; cmd_ready=0 throughout.
//  5 Timeout (macro on, TIMEOUT_CYCLES=16): rdy never asserted -> RESP after 16 WAIT cycles with err=1, rdata=0.
//    Repeat with rdy on the 16th WAIT cycle -> err=0.
//  6 Back-to-back: read then write, rsp_ready tied 1 -> both responses correct; bus_req low for >=2 cycles between transactions.

Source files
------------

// File: rtl/bus_master_pkg.sv
// Shared types for the bus_master_ctrl slice: command/bus modes and FSM states.
// The optional WAIT timeout is enabled by defining BUS_MASTER_TIMEOUT_EN.
package bus_master_pkg;

    // Transaction mode carried on cmd_mode / bus_mode.
    typedef enum logic [1:0] {
        MODE_RD   = 2'd0,
        MODE_WR   = 2'd1,
        MODE_RSV2 = 2'd2,
        MODE_RSV3 = 2'd3
    } mode_e;

    // Initiator FSM states, in the order a normal transaction visits them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Modes 2 and 3 are reserved; they have the upper bit set.
    function automatic logic mode_is_reserved(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/bus_master_timeout.sv
// WAIT-state watchdog for bus_master_ctrl. Counts cycles while enabled and
// flags when the count reaches TIMEOUT_CYCLES-1. Only instantiated when
// BUS_MASTER_TIMEOUT_EN is defined.
module bus_master_timeout
    import bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/bus_master_ctrl.sv
// Requester-side controller for the req/gnt/start/rdy bus. Takes one command
// at a time from a valid/ready stream, runs a single bus transaction and
// returns read data or an error on a valid/ready response channel.
// Optional feature: define BUS_MASTER_TIMEOUT_EN to abort a transaction that
// sits in WAIT for TIMEOUT_CYCLES cycles without bus_rdy.
//
// Handshake rule for both cmd and rsp channels: a transfer happens on a rising
// clk edge where valid and ready are both 1; valid, once raised, holds its
// payload stable until that edge, and ready may not depend on valid.
module bus_master_ctrl
    import bus_master_pkg::*;
#(
    parameter int AW             = 8,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // command channel
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    // response channel
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    // bus side
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic          bus_start,
    input  logic          bus_rdy,
    output logic [1:0]    bus_mode,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_data_o,
    output logic          bus_data_oe,
    input  logic [DW-1:0] bus_data_i,
    // debug view of the FSM state
    output state_e        dbg_state
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("bus_master_ctrl: TIMEOUT_CYCLES must be >= 2");
    end

    state_e        state_q;
    mode_e         mode_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;
    logic          bus_req_q;
    logic          bus_start_q;
    logic [1:0]    bus_mode_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_data_q;
    logic          bus_data_oe_q;

    // High in a WAIT cycle where the watchdog has run out.
    logic          timeout_hit;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic to_expired;

    // Counter restarts whenever the FSM is outside WAIT, so it reads 0 on entry.
    bus_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != WAIT),
        .en_i      ((state_q == WAIT) && !bus_rdy),
        .expired_o (to_expired)
    );

    assign timeout_hit = (state_q == WAIT) && to_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= MODE_RD;
            addr_q        <= '0;
            wdata_q       <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_start_q   <= 1'b0;
            bus_mode_q    <= '0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            bus_data_oe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // cmd_ready is 1 throughout IDLE, so valid alone means accept.
                    if (cmd_valid) begin
                        mode_q      <= mode_e'(cmd_mode);
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        cmd_ready_q <= 1'b0;
                        if (mode_is_reserved(cmd_mode)) begin
                            // Reserved mode: answer with an error, never touch the bus.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q   <= REQ;
                            bus_req_q <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (bus_gnt) begin
                        state_q     <= START;
                        bus_start_q <= 1'b1;
                        bus_mode_q  <= mode_q;
                        bus_addr_q  <= addr_q;
                        if (mode_q == MODE_WR) begin
                            bus_data_q    <= wdata_q;
                            bus_data_oe_q <= 1'b1;
                        end
                    end
                end

                START: begin
                    // Strobe lasts exactly one cycle; address/mode/data stay driven.
                    state_q     <= WAIT;
                    bus_start_q <= 1'b0;
                end

                WAIT: begin
                    // Grant loss is ignored here; only rdy or the watchdog ends WAIT.
                    // rdy beats a timeout landing on the same cycle.
                    if (bus_rdy || timeout_hit) begin
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= !bus_rdy;
                        rsp_rdata_q   <= (bus_rdy && (mode_q == MODE_RD)) ? bus_data_i : '0;
                        bus_req_q     <= 1'b0;
                        bus_mode_q    <= '0;
                        bus_addr_q    <= '0;
                        bus_data_q    <= '0;
                        bus_data_oe_q <= 1'b0;
                    end
                end

                RESP: begin
                    // Response is frozen until consumed, then cleared on the way out.
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q       <= IDLE;
                    cmd_ready_q   <= 1'b1;
                    rsp_valid_q   <= 1'b0;
                    rsp_rdata_q   <= '0;
                    rsp_err_q     <= 1'b0;
                    bus_req_q     <= 1'b0;
                    bus_start_q   <= 1'b0;
                    bus_mode_q    <= '0;
                    bus_addr_q    <= '0;
                    bus_data_q    <= '0;
                    bus_data_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign bus_req     = bus_req_q;
    assign bus_start   = bus_start_q;
    assign bus_mode    = bus_mode_q;
    assign bus_addr    = bus_addr_q;
    assign bus_data_o  = bus_data_q;
    assign bus_data_oe = bus_data_oe_q;
    assign dbg_state   = state_q;

endmodule
